load_store_unit: RTL and testbench

- Memory-stage initiator for the 256-word data memory.
- Accepts one load/store op from the pipeline, generates the memory's `request`/`we_re`/`address`/`mask`/`data_in` strobes, and captures `data_out`.
- Aligns, sign/zero-extends load data and returns it with a one-cycle response pulse.
- Byte-misaligned accesses that cross a word boundary are split into two word accesses; the pipeline stalls while the unit is busy.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_align.sv | 39 +++
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access-size decode.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC1,
      ST_ACC2,
      ST_DONE
   } lsu_state_e;

   // Access size in bytes from funct3[1:0]; the reserved 11 code decodes as a word.
   function automatic logic [2:0] size_bytes(input logic [1:0] size_code);
      case (size_code)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte-enable/store-data placement across two
// words, and load extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] lo,
   input  logic [31:0] hi,
   output logic [7:0]  m8,
   output logic [63:0] d64,
   output logic [31:0] load_data
);

   logic [7:0]  base_mask;
   logic [31:0] window;

   always_comb begin
      case (size_bytes(funct3[1:0]))
         3'd1:    base_mask = 8'h01;
         3'd2:    base_mask = 8'h03;
         default: base_mask = 8'h0F;
      endcase
      m8     = base_mask << offset;
      d64    = {32'b0, wdata} << {offset, 3'b000};
      window = 32'({hi, lo} >> {offset, 3'b000});

      // funct3[2] selects the unsigned variants of byte and halfword loads.
      case (funct3[1:0])
         2'b00:   load_data = funct3[2] ? {24'b0, window[7:0]}
                                        : {{24{window[7]}}, window[7:0]};
         2'b01:   load_data = funct3[2] ? {16'b0, window[15:0]}
                                        : {{16{window[15]}}, window[15:0]};
         default: load_data = window;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: one op at a time, word-crossing accesses
// optionally split into two word accesses, single-cycle response pulse.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_ADDR_W       = 8,
   parameter bit          SPLIT_MISALIGNED = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_load,
   input  logic                  req_store,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  rsp_valid,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  mem_request,
   output logic                  mem_we_re,
   output logic [MEM_ADDR_W-1:0] mem_address,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_mask,
   input  logic [31:0]           mem_rdata
);

   lsu_state_e            state_q, state_d;
   logic                  store_q, store_d;
   logic                  cross_q, cross_d;
   logic                  err_q, err_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [1:0]            offset_q, offset_d;
   logic [MEM_ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           lo_q, lo_d;
   logic [31:0]           hi_q, hi_d;

   logic [7:0]  m8;
   logic [63:0] d64;
   logic [31:0] load_data;
   logic        req_cross;
   logic        req_illegal;
   logic        unused_addr;

   assign unused_addr = ^req_addr[31:MEM_ADDR_W+2];

   lsu_align u_align (
      .funct3   (funct3_q),
      .offset   (offset_q),
      .wdata    (wdata_q),
      .lo       (lo_q),
      .hi       (hi_q),
      .m8       (m8),
      .d64      (d64),
      .load_data(load_data)
   );

   always_comb begin
      req_cross   = ({1'b0, req_addr[1:0]} + size_bytes(req_funct3[1:0])) > 3'd4;
      req_illegal = (req_load == req_store)
                 || (req_load && (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11))
                 || (req_store && (req_funct3 > F3_W))
                 || (!SPLIT_MISALIGNED && req_cross);
   end

   always_comb begin
      state_d  = state_q;
      store_d  = store_q;
      cross_d  = cross_q;
      err_d    = err_q;
      funct3_d = funct3_q;
      offset_d = offset_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      lo_d     = lo_q;
      hi_d     = hi_q;

      req_ready   = 1'b0;
      busy        = 1'b1;
      rsp_valid   = 1'b0;
      rsp_err     = 1'b0;
      rsp_rdata   = '0;
      mem_request = 1'b0;
      mem_we_re   = 1'b0;
      mem_address = '0;
      mem_wdata   = '0;
      mem_mask    = '0;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) begin
               store_d  = req_store;
               cross_d  = req_cross;
               err_d    = req_illegal;
               funct3_d = req_funct3;
               offset_d = req_addr[1:0];
               waddr_d  = req_addr[MEM_ADDR_W+1:2];
               wdata_d  = req_wdata;
               lo_d     = '0;
               hi_d     = '0;
               state_d  = req_illegal ? ST_DONE : ST_ACC1;
            end
         end
         ST_ACC1: begin
            mem_request = 1'b1;
            mem_we_re   = store_q;
            mem_address = waddr_q;
            mem_mask    = m8[3:0];
            mem_wdata   = d64[31:0];
            if (!store_q) lo_d = mem_rdata;
            state_d = cross_q ? ST_ACC2 : ST_DONE;
         end
         ST_ACC2: begin
            // Word address wraps modulo the memory size on the second half.
            mem_request = 1'b1;
            mem_we_re   = store_q;
            mem_address = waddr_q + 1'b1;
            mem_mask    = m8[7:4];
            mem_wdata   = d64[63:32];
            if (!store_q) hi_d = mem_rdata;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
            rsp_rdata = (err_q || store_q) ? '0 : load_data;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         store_q  <= 1'b0;
         cross_q  <= 1'b0;
         err_q    <= 1'b0;
         funct3_q <= '0;
         offset_q <= '0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
      end else begin
         state_q  <= state_d;
         store_q  <= store_d;
         cross_q  <= cross_d;
         err_q    <= err_d;
         funct3_q <= funct3_d;
         offset_q <= offset_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random ops
// checked against a byte-addressed memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_load, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, busy;
   logic [31:0] rsp_rdata;
   logic        mem_request, mem_we_re;
   logic [7:0]  mem_address;
   logic [31:0] mem_wdata, mem_rdata;
   logic [3:0]  mem_mask;

   int checks = 0;
   int errors = 0;

   logic [31:0] tbmem [256];
   logic [7:0]  ref_mem [1024];
   logic        fill_mem;

   // Per-op observations recorded by run_op
   int          acc_n, r_lat, r_busy;
   logic [7:0]  acc_addr [8];
   logic [3:0]  acc_mask [8];
   logic [31:0] acc_wdata [8];
   logic        acc_we [8];
   logic [31:0] r_rdata;
   logic        r_err, r_strobe_ok, r_single, r_ready;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_ADDR_W(8), .SPLIT_MISALIGNED(1'b1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_load(req_load), .req_store(req_store), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] m);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   assign mem_rdata = tbmem[mem_address];

   always @(posedge clk) begin
      if (fill_mem) begin
         for (int w = 0; w < 256; w++) tbmem[w] <= $urandom;
      end else if (mem_request && mem_we_re) begin
         tbmem[mem_address] <= merge(tbmem[mem_address], mem_wdata, mem_mask);
      end
   end

   // ---------------- reference model (byte-addressed, little-endian) -------
   function automatic bit m_illegal(input logic ld, input logic st, input logic [2:0] f3);
      return (ld == st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 > 2);
   endfunction

   function automatic int m_n(input logic [2:0] f3);
      return (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
   endfunction

   function automatic int m_lat(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr);
      if (m_illegal(ld, st, f3)) return 1;
      return (int'(addr[1:0]) + m_n(f3) > 4) ? 3 : 2;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr);
      logic [31:0] v = 0;
      int n = m_n(f3);
      for (int i = 0; i < n; i++)
         v = v | (32'(ref_mem[(int'(addr[9:0]) + i) % 1024]) << (8 * i));
      if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic m_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      for (int i = 0; i < m_n(f3); i++)
         ref_mem[(int'(addr[9:0]) + i) % 1024] = wd[8*i +: 8];
   endtask

   // ---------------- driver --------------------------------------------------
   task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
      bit got = 0;
      int k = 0;
      @(negedge clk);
      r_ready    = req_ready;
      req_valid  = 1'b1;
      req_load   = ld;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_load   = 1'($urandom);
      req_store  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      acc_n = 0; r_busy = 0; r_strobe_ok = 1'b1; r_lat = -1;
      while (!got && k < 10) begin
         @(negedge clk);
         k++;
         if (busy) r_busy++;
         if (mem_request) begin
            if (acc_n < 8) begin
               acc_addr[acc_n] = mem_address; acc_mask[acc_n] = mem_mask;
               acc_wdata[acc_n] = mem_wdata;  acc_we[acc_n] = mem_we_re;
            end
            acc_n++;
         end else if (mem_we_re || mem_mask != 0 || mem_address != 0 || mem_wdata != 0) begin
            r_strobe_ok = 1'b0;
         end
         if (rsp_valid) begin
            got = 1; r_lat = k; r_rdata = rsp_rdata; r_err = rsp_err;
         end
      end
      @(negedge clk);
      r_single = !rsp_valid && req_ready && !busy;
      if (!m_illegal(ld, st, f3) && st) m_store(f3, addr, wd);
   endtask

   // ---------------- tests ---------------------------------------------------
   task automatic test_reset();
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
      checks++; if ({busy, rsp_valid, rsp_err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {busy, rsp_valid, rsp_err}); end
      checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata); end
      checks++; if ({mem_request, mem_we_re, mem_mask, mem_address, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem: got req=%b we=%b mask=%h addr=%h wdata=%h expected all 0", mem_request, mem_we_re, mem_mask, mem_address, mem_wdata); end
   endtask

   task automatic test_aligned_store();
      run_op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b expected 1", r_ready); end
      checks++; if (r_lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d expected 2", r_lat); end
      checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL sw_err: got %b expected 0", r_err); end
      checks++; if (acc_n !== 1) begin errors++; $display("FAIL sw_count: got %0d expected 1", acc_n); end
      checks++; if ({acc_addr[0], acc_mask[0], acc_we[0]} !== {8'd4, 4'b1111, 1'b1}) begin errors++; $display("FAIL sw_strobe: got addr=%h mask=%b we=%b expected 04 1111 1", acc_addr[0], acc_mask[0], acc_we[0]); end
      checks++; if (acc_wdata[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", acc_wdata[0]); end
      checks++; if (r_single !== 1'b1) begin errors++; $display("FAIL sw_single_pulse: got %b expected 1", r_single); end
      checks++; if (tbmem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_memword: got %h expected deadbeef", tbmem[4]); end
   endtask

   task automatic test_byte_loads();
      run_op(1'b0, 1'b1, 3'b010, 32'h10, 32'h81223344);
      run_op(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
      checks++; if (r_rdata !== 32'hFFFFFF81) begin errors++; $display("FAIL lb: got %h expected ffffff81", r_rdata); end
      checks++; if (r_lat !== 2) begin errors++; $display("FAIL lb_latency: got %0d expected 2", r_lat); end
      run_op(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
      checks++; if (r_rdata !== 32'h00000081) begin errors++; $display("FAIL lbu: got %h expected 00000081", r_rdata); end
      run_op(1'b1, 1'b0, 3'b001, 32'h10, 32'h0);
      checks++; if (r_rdata !== 32'h00003344) begin errors++; $display("FAIL lh: got %h expected 00003344", r_rdata); end
   endtask

   task automatic test_crossing();
      run_op(1'b0, 1'b1, 3'b001, 32'h03, 32'h0000ABCD);
      checks++; if (acc_n !== 2 || r_lat !== 3) begin errors++; $display("FAIL sh_cross_shape: got n=%0d lat=%0d expected 2 3", acc_n, r_lat); end
      checks++; if ({acc_addr[0], acc_mask[0], acc_wdata[0][31:24]} !== {8'd0, 4'b1000, 8'hCD}) begin errors++; $display("FAIL sh_cross_acc1: got addr=%h mask=%b b3=%h expected 00 1000 cd", acc_addr[0], acc_mask[0], acc_wdata[0][31:24]); end
      checks++; if ({acc_addr[1], acc_mask[1], acc_wdata[1][7:0]} !== {8'd1, 4'b0001, 8'hAB}) begin errors++; $display("FAIL sh_cross_acc2: got addr=%h mask=%b b0=%h expected 01 0001 ab", acc_addr[1], acc_mask[1], acc_wdata[1][7:0]); end
      run_op(1'b1, 1'b0, 3'b101, 32'h03, 32'h0);
      checks++; if (r_rdata !== 32'h0000ABCD) begin errors++; $display("FAIL lhu_cross: got %h expected 0000abcd", r_rdata); end
      checks++; if (r_busy !== 3) begin errors++; $display("FAIL lhu_cross_busy: got %0d expected 3", r_busy); end
   endtask

   task automatic test_wrap();
      run_op(1'b0, 1'b1, 3'b010, 32'h3FC, 32'h1122AABB);
      run_op(1'b0, 1'b1, 3'b010, 32'h000, 32'h3344CCDD);
      run_op(1'b1, 1'b0, 3'b010, 32'h3FE, 32'h0);
      checks++; if (acc_n !== 2 || acc_addr[0] !== 8'd255 || acc_addr[1] !== 8'd0) begin errors++; $display("FAIL wrap_addr: got n=%0d a0=%h a1=%h expected 2 ff 00", acc_n, acc_addr[0], acc_addr[1]); end
      checks++; if (r_rdata !== 32'hCCDD1122) begin errors++; $display("FAIL wrap_rdata: got %h expected ccdd1122", r_rdata); end
   endtask

   task automatic test_illegal();
      logic [4:0] ops [5] = '{5'b10_011, 5'b11_010, 5'b00_000, 5'b10_110, 5'b01_100};
      logic [4:0] op;
      for (int i = 0; i < 5; i++) begin
         op = ops[i];
         run_op(op[4], op[3], op[2:0], $urandom, $urandom);
         checks++; if (acc_n !== 0) begin errors++; $display("FAIL illegal_noaccess[%0d]: got %0d accesses expected 0", i, acc_n); end
         checks++; if ({r_lat, r_err, r_rdata} !== {32'd1, 1'b1, 32'h0}) begin errors++; $display("FAIL illegal_rsp[%0d]: got lat=%0d err=%b rdata=%h expected 1 1 0", i, r_lat, r_err, r_rdata); end
      end
   endtask

   task automatic test_reset_midop();
      bit pulsed = 0;
      @(negedge clk);
      req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h2;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (mem_request !== 1'b1 || mem_address !== 8'd1) begin errors++; $display("FAIL midop_acc2: got req=%b addr=%h expected 1 01", mem_request, mem_address); end
      rst = 1'b1;
      #1;
      checks++; if ({mem_request, busy, req_ready} !== 3'b001) begin errors++; $display("FAIL midop_async: got req=%b busy=%b ready=%b expected 0 0 1", mem_request, busy, req_ready); end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rsp_valid) pulsed = 1;
      end
      checks++; if (pulsed) begin errors++; $display("FAIL midop_no_rsp: got rsp_valid pulse expected none"); end
      run_op(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
      checks++; if (r_lat !== 2 || r_err !== 1'b0 || r_rdata !== m_load(3'b010, 32'h0)) begin errors++; $display("FAIL midop_after_lw: got lat=%0d err=%b rdata=%h expected 2 0 %h", r_lat, r_err, r_rdata, m_load(3'b010, 32'h0)); end
   endtask

   task automatic test_random();
      logic ld, st;
      logic [2:0] f3;
      logic [31:0] addr, wd, exp_rdata;
      int exp_lat, sel;
      bit ill;
      for (int t = 0; t < 300; t++) begin
         sel = $urandom_range(0, 11);
         ld = (sel == 0) || (sel >= 2 && sel < 7);
         st = (sel == 0) || (sel >= 7);
         f3 = 3'($urandom);
         addr = $urandom;
         wd = $urandom;
         ill = m_illegal(ld, st, f3);
         exp_lat = m_lat(ld, st, f3, addr);
         exp_rdata = (ill || st) ? 32'h0 : m_load(f3, addr);
         run_op(ld, st, f3, addr, wd);
         checks++; if (r_lat !== exp_lat) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", t, r_lat, exp_lat); end
         checks++; if (r_err !== ill) begin errors++; $display("FAIL rnd_err[%0d]: got %b expected %b", t, r_err, ill); end
         checks++; if (r_rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata[%0d]: got %h expected %h (ld=%b st=%b f3=%b addr=%h)", t, r_rdata, exp_rdata, ld, st, f3, addr); end
         checks++; if (acc_n !== exp_lat - 1) begin errors++; $display("FAIL rnd_accesses[%0d]: got %0d expected %0d", t, acc_n, exp_lat - 1); end
         checks++; if (!r_strobe_ok || !r_single || !r_ready) begin errors++; $display("FAIL rnd_idle_strobes[%0d]: got strobe_ok=%b single=%b ready=%b expected 1 1 1", t, r_strobe_ok, r_single, r_ready); end
      end
      for (int w = 0; w < 256; w++) begin
         checks++;
         if (tbmem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) begin
            errors++;
            $display("FAIL final_mem[%0d]: got %h expected %h", w, tbmem[w], {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
         end
      end
   endtask

   initial begin
      rst = 1'b1; fill_mem = 1'b1;
      req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
      req_funct3 = '0; req_addr = '0; req_wdata = '0;
      @(negedge clk);
      fill_mem = 1'b0;
      @(negedge clk);
      test_reset();
      for (int w = 0; w < 256; w++)
         for (int b = 0; b < 4; b++) ref_mem[4*w+b] = tbmem[w][8*b +: 8];
      rst = 1'b0;
      test_aligned_store();
      test_byte_loads();
      test_crossing();
      test_wrap();
      test_illegal();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
